// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUB_ADD_EN (adds a mode bit selecting add).
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2, used to size the bit counter at elaboration time.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Handshake bundle for serial_sub: operand side and result side.
// Optional feature macro: SERIAL_SUB_ADD_EN (adds the mode signal).
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
`ifdef SERIAL_SUB_ADD_EN
  logic             mode;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

`ifdef SERIAL_SUB_ADD_EN
  modport master (output in_valid, a, b, bin, mode, out_ready,
                  input  in_ready, out_valid, diff, borrow);
  modport slave  (input  in_valid, a, b, bin, mode, out_ready,
                  output in_ready, out_valid, diff, borrow);
`else
  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, borrow);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, borrow);
`endif
endinterface

// File: rtl/serial_sub_full_sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow-out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// A single full_sub_cell is reused every cycle; the borrow register chains bits.
// Optional feature macro: SERIAL_SUB_ADD_EN. When defined, mode=1 turns the
// block into an adder by inverting b and running the borrow chain with
// inverted polarity (borrow = ~carry), so the same cell serves both.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  serial_sub_if.slave bus
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] diff_q;
  logic             brw_q;
  logic             vld_q;
  logic             cell_b;
  logic             cell_d;
  logic             cell_bout;

`ifdef SERIAL_SUB_ADD_EN
  logic             mode_q;
  // Add mode: a + b + c == a - ~b - ~c, with carry-out == ~borrow-out.
  assign cell_b     = b_sh_q[0] ^ mode_q;
  assign bus.borrow = brw_q ^ mode_q;
`else
  assign cell_b     = b_sh_q[0];
  assign bus.borrow = brw_q;
`endif

  full_sub_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (cell_b),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = vld_q;
  assign bus.diff      = diff_q;

  // Control FSM plus operand/result shift registers and borrow chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
`ifdef SERIAL_SUB_ADD_EN
            mode_q  <= bus.mode;
            brw_q   <= bus.bin ^ bus.mode;
`else
            brw_q   <= bus.bin;
`endif
          end
        end
        ST_BUSY: begin
          diff_q <= {cell_d, diff_q[WIDTH-1:1]};
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          brw_q  <= cell_bout;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= ST_DONE;
            vld_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 directed + random ops,
// WIDTH=3 exhaustive sweep with random result stalls.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) if8 ();
  serial_sub_if #(.WIDTH(3)) if3 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_sub #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic; low W bits are the result,
  // bit W is borrow (sub, negative result) or carry-out (add).
  function automatic int ref_op(input int a, input int b, input int bin, input int m);
    return (m != 0) ? (a + b + bin) : (a - b - bin);
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic m, input int stall, input bit scramble);
    int r, lat, mm;
`ifdef SERIAL_SUB_ADD_EN
    mm = int'(m);
    if8.mode = m;
`else
    mm = 0;
`endif
    r = ref_op(int'(a), int'(b), int'(bin), mm);
    lat = 0;
    while (!if8.in_ready && lat < 40) begin tick; lat++; end
    chk("w8_in_ready_idle", 32'(if8.in_ready), 32'd1);
    if8.a = a; if8.b = b; if8.bin = bin; if8.in_valid = 1'b1;
    tick;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin tick; lat++; end
    chk("w8_latency", 32'(lat), 32'd8);
    chk("w8_diff", 32'(if8.diff), 32'(r & 255));
    chk("w8_borrow", 32'(if8.borrow), 32'((r >> 8) & 1));
    for (int i = 0; i < stall; i++) begin
      if (scramble) begin
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.in_valid = 1'b1;
      end
      tick;
      chk("w8_hold_vld", 32'(if8.out_valid), 32'd1);
      chk("w8_hold_diff", 32'(if8.diff), 32'(r & 255));
      chk("w8_hold_brw", 32'(if8.borrow), 32'((r >> 8) & 1));
      chk("w8_done_in_ready", 32'(if8.in_ready), 32'd0);
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    tick;
    if8.out_ready = 1'b0;
    chk("w8_vld_drop", 32'(if8.out_valid), 32'd0);
    chk("w8_back_idle", 32'(if8.in_ready), 32'd1);
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic bin,
                     input logic m);
    int r, lat, mm, stall;
`ifdef SERIAL_SUB_ADD_EN
    mm = int'(m);
    if3.mode = m;
`else
    mm = 0;
`endif
    r = ref_op(int'(a), int'(b), int'(bin), mm);
    if3.a = a; if3.b = b; if3.bin = bin; if3.in_valid = 1'b1;
    tick;
    if3.in_valid = 1'b0;
    lat = 0;
    while (!if3.out_valid && lat < 40) begin tick; lat++; end
    chk("w3_latency", 32'(lat), 32'd3);
    stall = int'($urandom_range(0, 3));
    for (int i = 0; i < stall; i++) tick;
    chk("w3_diff", 32'(if3.diff), 32'(r & 7));
    chk("w3_borrow", 32'(if3.borrow), 32'((r >> 3) & 1));
    if3.out_ready = 1'b1;
    tick;
    if3.out_ready = 1'b0;
    chk("w3_vld_drop", 32'(if3.out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
    if3.in_valid = 1'b0; if3.out_ready = 1'b0; if3.a = '0; if3.b = '0; if3.bin = 1'b0;
`ifdef SERIAL_SUB_ADD_EN
    if8.mode = 1'b0; if3.mode = 1'b0;
`endif
    tick; tick;
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_diff", 32'(if8.diff), 32'd0);
    chk("rst_borrow", 32'(if8.borrow), 32'd0);
    chk("rst_in_ready", 32'(if8.in_ready), 32'd1);
    rst_n = 1'b1;
    tick;

    // Directed corners
    op8(8'h00, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    op8(8'h5A, 8'h5A, 1'b1, 1'b0, 0, 1'b0);
    op8(8'hFF, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    // Backpressure with operand churn and in_valid asserted while DONE
    op8(8'h37, 8'hC2, 1'b1, 1'b0, 5, 1'b1);

    // Reset in the middle of BUSY
    if8.a = 8'h33; if8.b = 8'h11; if8.bin = 1'b0; if8.in_valid = 1'b1;
    tick;
    if8.in_valid = 1'b0;
    tick; tick; tick;
    rst_n = 1'b0;
    #2;
    chk("midrst_vld", 32'(if8.out_valid), 32'd0);
    chk("midrst_diff", 32'(if8.diff), 32'd0);
    chk("midrst_in_ready", 32'(if8.in_ready), 32'd1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("postrst_vld", 32'(if8.out_valid), 32'd0);
    op8(8'h10, 8'h01, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
    op8(8'hF0, 8'h20, 1'b1, 1'b1, 0, 1'b0);
    op8(8'hF0, 8'h20, 1'b1, 1'b0, 0, 1'b0);
`endif

    // Random WIDTH=8 ops
    for (int k = 0; k < 24; k++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 2)), 1'($urandom));

    // Exhaustive WIDTH=3 sweep
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++)
          op3(3'(ia), 3'(ib), 1'(ic), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
